// File: rtl/pitch_pkg.sv
// Shared types for the pitch-shift bin path: complex bin layout, reader states
// and the saturating conjugate used on the read side.
package pitch_pkg;

    localparam int BIN_SIZE = 32;
    localparam int BIN_HALF = BIN_SIZE / 2;

    typedef struct packed {
        logic signed [BIN_HALF-1:0] re;
        logic signed [BIN_HALF-1:0] im;
    } bin_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } rd_state_t;

    // The most negative imag value has no positive twin, so it clamps to max.
    function automatic bin_t conj_sat(input bin_t b);
        bin_t r;
        r.re = b.re;
        if (b.im == {1'b1, {(BIN_HALF-1){1'b0}}}) begin
            r.im = {1'b0, {(BIN_HALF-1){1'b1}}};
        end else begin
            r.im = -b.im;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_fifo2.sv
// Two-entry register FIFO; the head register drives the stream outputs directly
// so downstream ready never reaches them combinationally.
module bin_fifo2 #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign head  = r_head;

    // Illegal requests are dropped here so the count can never leave 0..2.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // NOTE: the data registers are reset too, because the head drives m_data and
    // that output must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= din;
                    else                 r_tail <= din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bin_stream_reader.sv
// Read-side sequencer: sweeps the bin buffer once per start and streams the
// (optionally conjugated) bins to the IFFT through a 2-entry FIFO.
module bin_stream_reader
    import pitch_pkg::*;
#(
    parameter int SIZE    = BIN_SIZE,
    parameter int SAMPLES = 2048,
    parameter int IDX_W   = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             conj_en,
    output logic [IDX_W-1:0] rd_index,
    input  logic [SIZE-1:0]  rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [SIZE-1:0]  m_data,
    output logic [IDX_W-1:0] m_index,
    output logic             m_last,
    output logic             busy,
    output logic             frame_done
);

    localparam int               ENT_W    = SIZE + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic [IDX_W-1:0] r_rd_index;
    logic             r_conj;
    logic             r_frame_done;
    logic             w_done_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_at_last;
    bin_t             w_bin_in;
    bin_t             w_bin_out;
    logic [ENT_W-1:0] w_head;

    assign w_bin_in  = rd_data;
    assign w_bin_out = r_conj ? conj_sat(w_bin_in) : w_bin_in;
    assign w_at_last = (r_rd_index == LAST_IDX);
    assign w_pop     = ~w_empty & m_ready;
    // A full FIFO still accepts a bin in the same cycle its head leaves.
    assign w_push    = (r_state == STREAM) & ~abort & (~w_full | w_pop);

    bin_fifo2 #(.W(ENT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (abort),
        .din   ({w_bin_out, r_rd_index, w_at_last}),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_nxt = STREAM;
            STREAM:  if (w_push && w_at_last) w_state_nxt = DRAIN;
            DRAIN: begin
                if (w_pop && w_head[0]) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rd_index   <= '0;
            r_conj       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_done_nxt;
            if (abort) begin
                r_rd_index <= '0;
            end else if (r_state == IDLE && start) begin
                r_rd_index <= '0;
                r_conj     <= conj_en;
            end else if (w_push && !w_at_last) begin
                r_rd_index <= r_rd_index + IDX_W'(1);
            end
        end
    end

    assign rd_index   = r_rd_index;
    assign m_valid    = ~w_empty;
    assign m_data     = w_head[ENT_W-1 -: SIZE];
    assign m_index    = w_head[IDX_W:1];
    assign m_last     = w_head[0];
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bin_stream_reader.sv
// Scoreboard bench for bin_stream_reader with an 8-bin frame: stimulus queues
// expected bins, a negedge monitor pops and compares every accepted bin.
module tb_bin_stream_reader;

    localparam int SIZE    = 32;
    localparam int SAMPLES = 8;
    localparam int IDX_W   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             conj_en = 1'b0;
    logic             m_ready = 1'b0;
    logic [IDX_W-1:0] rd_index;
    logic [SIZE-1:0]  rd_data;
    logic             m_valid;
    logic [SIZE-1:0]  m_data;
    logic [IDX_W-1:0] m_index;
    logic             m_last;
    logic             busy;
    logic             frame_done;

    logic [SIZE-1:0] mem [SAMPLES];
    assign rd_data = mem[rd_index];

    bin_stream_reader #(.SIZE(SIZE), .SAMPLES(SAMPLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .conj_en    (conj_en),
        .rd_index   (rd_index),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_note(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Ready generator: manual level, or the repeating 1,0,0,1 pattern.
    int         ready_mode = 0;
    logic       ready_man  = 1'b0;
    logic [3:0] ready_pat  = 4'b1001;
    int         ready_ph   = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            m_ready = ready_man;
        end else begin
            m_ready  = ready_pat[ready_ph];
            ready_ph = (ready_ph + 1) % 4;
        end
    end

    // Scoreboard monitor.
    logic [35:0] exp_q [$];
    logic [35:0] prev_out = '0;
    bit          prev_stall = 1'b0;
    int          n_hs = 0;
    int          n_done = 0;
    int          fifo_max = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_stable", {m_valid, m_data, m_index, m_last}, {1'b1, prev_out});
            if (m_valid && m_ready) begin
                n_hs++;
                if (exp_q.size() == 0) fail_note("unexpected_bin", {m_data, m_index, m_last});
                else check("bin_out", {m_data, m_index, m_last}, exp_q.pop_front());
            end
            if (frame_done) n_done++;
            if (int'(dut.u_fifo.r_count) > fifo_max) fifo_max = int'(dut.u_fifo.r_count);
            prev_stall = m_valid && !m_ready && !abort;
            prev_out   = {m_data, m_index, m_last};
        end
    end

    function automatic logic [31:0] conj_model(input logic [31:0] d);
        logic [15:0] im;
        im = d[15:0];
        if (im == 16'h8000) return {d[31:16], 16'h7FFF};
        return {d[31:16], -im};
    endfunction

    task automatic push_frame(input bit conj);
        logic [31:0] d;
        for (int i = 0; i < SAMPLES; i++) begin
            d = conj ? conj_model(mem[i]) : mem[i];
            exp_q.push_back({d, 3'(i), (i == SAMPLES - 1)});
        end
    endtask

    int start_cyc = 0;

    task automatic pulse_start(input bit conj);
        @(posedge clk); #1;
        start     = 1'b1;
        conj_en   = conj;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int dcyc, output bit ok);
        ok   = 1'b0;
        dcyc = -1;
        for (int t = 0; t < max_cyc; t++) begin
            @(negedge clk); #1;
            if (frame_done) begin
                ok   = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"},    m_valid,    1'b0);
        check({tag, "_m_data"},     m_data,     32'h0);
        check({tag, "_m_index"},    m_index,    3'd0);
        check({tag, "_m_last"},     m_last,     1'b0);
        check({tag, "_busy"},       busy,       1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_rd_index"},   rd_index,   3'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dcyc;
        bit          ok;
        int          t;
        int          base_hs;
        int          base_done;
        logic [15:0] r;
        logic [31:0] d;

        for (int i = 0; i < SAMPLES; i++) begin
            r      = 16'(i);
            mem[i] = {r, -r};
        end

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        ready_man = 1'b1;

        // Basic frame with m_ready held high.
        push_frame(1'b0);
        pulse_start(1'b0);
        t = 0;
        while (!m_valid && t < 10) begin
            @(negedge clk); #1;
            t++;
        end
        check("first_valid_latency", 64'(cyc - start_cyc), 64'd2);
        wait_done(40, dcyc, ok);
        check("basic_done_seen", ok, 1'b1);
        check("basic_done_cycle", 64'(dcyc - start_cyc), 64'd10);
        check("basic_busy_at_done", busy, 1'b0);
        check("basic_all_delivered", exp_q.size(), 0);

        // Backpressure with the 1,0,0,1 ready pattern.
        ready_mode = 1;
        base_hs    = n_hs;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done(100, dcyc, ok);
        check("bp_done_seen", ok, 1'b1);
        check("bp_delivered_count", n_hs - base_hs, 8);
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_fifo_max_le2", fifo_max <= 2, 1'b1);
        @(negedge clk); #1;
        ready_mode = 0;
        ready_man  = 1'b1;

        // Conjugation with saturation; conj_en toggles mid-frame.
        mem[3] = 32'h0005_8000;
        mem[4] = 32'hFFFF_0007;
        for (int i = 0; i < SAMPLES; i++) begin
            if (i == 3)      d = 32'h0005_7FFF;
            else if (i == 4) d = 32'hFFFF_FFF9;
            else             d = conj_model(mem[i]);
            exp_q.push_back({d, 3'(i), (i == SAMPLES - 1)});
        end
        pulse_start(1'b1);
        for (int i = 0; i < 6; i++) begin
            conj_en = ~conj_en;
            @(posedge clk); #1;
        end
        conj_en = 1'b0;
        wait_done(40, dcyc, ok);
        check("conj_done_seen", ok, 1'b1);
        check("conj_queue_empty", exp_q.size(), 0);

        // Abort mid-frame with a full FIFO, start asserted alongside.
        for (int i = 0; i < SAMPLES; i++) begin
            r      = 16'(i);
            mem[i] = {r, -r};
        end
        base_done = n_done;
        push_frame(1'b0);
        pulse_start(1'b0);
        base_hs = n_hs - 0;
        base_hs = base_hs;
        t = 0;
        while (n_hs - base_hs < 4 && t < 30) begin
            @(negedge clk); #1;
            t++;
        end
        check("abort_four_seen", n_hs - base_hs, 4);
        ready_man = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_precond_full", dut.w_full, 1'b1);
        check("abort_precond_valid", m_valid, 1'b1);
        abort = 1'b1;
        start = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_m_valid", m_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rd_index", rd_index, 3'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", n_done - base_done, 0);
        check("abort_stays_idle", busy, 1'b0);
        @(negedge clk); #1;
        ready_man = 1'b1;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done(40, dcyc, ok);
        check("replay_done_seen", ok, 1'b1);
        check("replay_queue_empty", exp_q.size(), 0);

        // Start while busy is ignored.
        base_done = n_done;
        push_frame(1'b0);
        pulse_start(1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, dcyc, ok);
        check("busy_start_done_seen", ok, 1'b1);
        check("busy_start_done_cycle", 64'(dcyc - start_cyc), 64'd10);
        repeat (15) @(posedge clk);
        #1;
        check("busy_start_one_frame", n_done - base_done, 1);
        check("busy_start_queue_empty", exp_q.size(), 0);
        check("busy_start_idle", busy, 1'b0);

        // Asynchronous reset mid-frame.
        push_frame(1'b0);
        pulse_start(1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_frame(1'b0);
        pulse_start(1'b0);
        wait_done(40, dcyc, ok);
        check("post_reset_done_seen", ok, 1'b1);
        check("post_reset_queue_empty", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
